mux_41: RTL and testbench



---
 rtl/mux_41.sv | 67 ++++++
 tb/tb_mux_41.sv | 219 +++++++++++++++++++++
 2 files changed

// File: rtl/mux_41.sv
// Registered 4-to-1 multiplexer: a two-level tree of 2:1 cells feeding one
// output register with synchronous active-low reset.

module mux_21_cell #(
  parameter int WIDTH = 1
) (
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             sel,
  output logic [WIDTH-1:0] y
);

  assign y = sel ? b : a;

endmodule

module mux_41 #(
  parameter int WIDTH = 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] i0,
  input  logic [WIDTH-1:0] i1,
  input  logic [WIDTH-1:0] i2,
  input  logic [WIDTH-1:0] i3,
  input  logic             s1,
  input  logic             s0,
  output logic [WIDTH-1:0] out
);

  logic [WIDTH-1:0] cell_a_y;
  logic [WIDTH-1:0] cell_b_y;
  logic [WIDTH-1:0] sel_d;

  // First level picks within each pair on s0; second level picks the pair on s1.
  mux_21_cell #(.WIDTH(WIDTH)) u_cell_a (
    .a   (i0),
    .b   (i1),
    .sel (s0),
    .y   (cell_a_y)
  );

  mux_21_cell #(.WIDTH(WIDTH)) u_cell_b (
    .a   (i2),
    .b   (i3),
    .sel (s0),
    .y   (cell_b_y)
  );

  mux_21_cell #(.WIDTH(WIDTH)) u_cell_top (
    .a   (cell_a_y),
    .b   (cell_b_y),
    .sel (s1),
    .y   (sel_d)
  );

  // NOTE: non-blocking assignment keeps every register reading pre-edge values;
  // reset is tested first so it wins over data on the same edge.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      out <= '0;
    end else begin
      out <= sel_d;
    end
  end

endmodule

// File: tb/tb_mux_41.sv
// Directed self-checking bench for mux_41: a WIDTH=1 instance for the
// exhaustive sweep and a WIDTH=8 instance for the multi-bit scenarios.

module tb_mux_41;

  logic       clk;
  logic       rst_n;
  logic       s1;
  logic       s0;
  logic       n0, n1, n2, n3;
  logic       nout;
  logic [7:0] w0, w1, w2, w3;
  logic [7:0] wout;

  int checks = 0;
  int errors = 0;

  mux_41 #(.WIDTH(1)) u_dut1 (
    .clk   (clk),
    .rst_n (rst_n),
    .i0    (n0),
    .i1    (n1),
    .i2    (n2),
    .i3    (n3),
    .s1    (s1),
    .s0    (s0),
    .out   (nout)
  );

  mux_41 #(.WIDTH(8)) u_dut8 (
    .clk   (clk),
    .rst_n (rst_n),
    .i0    (w0),
    .i1    (w1),
    .i2    (w2),
    .i3    (w3),
    .s1    (s1),
    .s0    (s0),
    .out   (wout)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Advance one rising edge, then settle so outputs are sampled off the edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    {n0, n1, n2, n3} = 4'b1111;
    w0 = 8'h01; w1 = 8'h01; w2 = 8'h01; w3 = 8'h01;
    {s1, s0} = 2'b11;
    for (int e = 0; e < 2; e++) begin
      tick();
      checks++;
      if (nout !== 1'b0) begin
        errors++;
        $display("FAIL reset_w1 edge %0d: got %b expected 0", e, nout);
      end
      checks++;
      if (wout !== 8'h00) begin
        errors++;
        $display("FAIL reset_w8 edge %0d: got %h expected 00", e, wout);
      end
    end
    rst_n = 1'b1;
    tick();
    checks++;
    if (nout !== 1'b1) begin
      errors++;
      $display("FAIL reset_release_w1: got %b expected 1", nout);
    end
    checks++;
    if (wout !== 8'h01) begin
      errors++;
      $display("FAIL reset_release_w8: got %h expected 01", wout);
    end
  endtask

  task automatic test_sweep();
    logic [5:0] v;
    logic       exp;
    for (int c = 0; c < 64; c++) begin
      v = 6'(c);
      n0 = v[0]; n1 = v[1]; n2 = v[2]; n3 = v[3];
      s0 = v[4]; s1 = v[5];
      case (v[5:4])
        2'b00:   exp = v[0];
        2'b01:   exp = v[1];
        2'b10:   exp = v[2];
        default: exp = v[3];
      endcase
      tick();
      checks++;
      if (nout !== exp) begin
        errors++;
        $display("FAIL sweep combo %0d: got %b expected %b", c, nout, exp);
      end
    end
  endtask

  task automatic test_one_hot_walk();
    logic [7:0] exp [4] = '{8'h11, 8'h22, 8'h44, 8'h88};
    w0 = 8'h11; w1 = 8'h22; w2 = 8'h44; w3 = 8'h88;
    for (int k = 0; k < 4; k++) begin
      {s1, s0} = 2'(k);
      tick();
      checks++;
      if (wout !== exp[k]) begin
        errors++;
        $display("FAIL one_hot sel %0d: got %h expected %h", k, wout, exp[k]);
      end
    end
  endtask

  task automatic test_back_to_back();
    logic [1:0] seq [6] = '{2'b11, 2'b00, 2'b10, 2'b01, 2'b01, 2'b10};
    logic [7:0] exp [6] = '{8'hF0, 8'hA5, 8'h0F, 8'h3C, 8'h3C, 8'h0F};
    w0 = 8'hA5; w1 = 8'h3C; w2 = 8'h0F; w3 = 8'hF0;
    for (int k = 0; k < 6; k++) begin
      {s1, s0} = seq[k];
      tick();
      checks++;
      if (wout !== exp[k]) begin
        errors++;
        $display("FAIL back_to_back step %0d: got %h expected %h", k, wout, exp[k]);
      end
    end
  endtask

  task automatic test_latency();
    {s1, s0} = 2'b10;
    w2 = 8'h00;
    tick();
    checks++;
    if (wout !== 8'h00) begin
      errors++;
      $display("FAIL latency_setup: got %h expected 00", wout);
    end
    w2 = 8'h01;
    #3;
    checks++;
    if (wout !== 8'h00) begin
      errors++;
      $display("FAIL latency_early: got %h expected 00", wout);
    end
    tick();
    checks++;
    if (wout !== 8'h01) begin
      errors++;
      $display("FAIL latency_edge: got %h expected 01", wout);
    end
  endtask

  task automatic test_reset_mid();
    w3 = 8'h88;
    {s1, s0} = 2'b11;
    tick();
    checks++;
    if (wout !== 8'h88) begin
      errors++;
      $display("FAIL reset_mid_pre: got %h expected 88", wout);
    end
    rst_n = 1'b0;
    tick();
    checks++;
    if (wout !== 8'h00) begin
      errors++;
      $display("FAIL reset_mid_assert: got %h expected 00", wout);
    end
    rst_n = 1'b1;
    tick();
    checks++;
    if (wout !== 8'h88) begin
      errors++;
      $display("FAIL reset_mid_restore: got %h expected 88", wout);
    end
  endtask

  task automatic test_simultaneous();
    w0 = 8'h5A;
    w3 = 8'h00;
    {s1, s0} = 2'b00;
    tick();
    checks++;
    if (wout !== 8'h5A) begin
      errors++;
      $display("FAIL simultaneous_pre: got %h expected 5a", wout);
    end
    {s1, s0} = 2'b11;
    w3 = 8'hFF;
    tick();
    checks++;
    if (wout !== 8'hFF) begin
      errors++;
      $display("FAIL simultaneous_switch: got %h expected ff", wout);
    end
  endtask

  initial begin
    rst_n = 1'b0;
    s1 = 1'b0; s0 = 1'b0;
    n0 = 1'b0; n1 = 1'b0; n2 = 1'b0; n3 = 1'b0;
    w0 = '0; w1 = '0; w2 = '0; w3 = '0;
    test_reset();
    test_sweep();
    test_one_hot_walk();
    test_back_to_back();
    test_latency();
    test_reset_mid();
    test_simultaneous();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
